// File: rtl/converge_pkg.sv
// rtl/converge_pkg.sv - shared types, mode codes and width helper for the convergence checker
package converge_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic MODE_SSQ    = 1'b0;
  localparam logic MODE_MAXABS = 1'b1;

  // Room for the worst-case sum of N*N full-scale squares without overflow.
  function automatic int metric_width(input int width, input int n);
    return 2 * width + $clog2(n * n);
  endfunction

endpackage

// File: rtl/converge_metric_acc.sv
// rtl/converge_metric_acc.sv - sum-of-squares / max-abs accumulator for one frame
module converge_metric_acc
  import converge_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MW    = 36
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clear,
  input  logic                    mode,
  input  logic                    diag,
  input  logic signed [WIDTH-1:0] element,
  output logic [MW-1:0]           metric
);

  logic [MW-1:0]           acc;
  logic [MW-1:0]           base;
  logic signed [2*WIDTH-1:0] sq;
  logic signed [WIDTH:0]   ext;
  logic [WIDTH:0]          mag;
  logic [MW-1:0]           sq_ext;
  logic [MW-1:0]           mag_ext;

  assign sq      = element * element;
  // One extra bit so the magnitude of the most negative value is exact.
  assign ext     = {element[WIDTH-1], element};
  assign mag     = ext[WIDTH] ? $unsigned(-ext) : $unsigned(ext);
  assign sq_ext  = {{(MW-2*WIDTH){1'b0}}, $unsigned(sq)};
  assign mag_ext = {{(MW-WIDTH-1){1'b0}}, mag};

  // metric already includes the element offered this cycle, so the frame's
  // final value is available on the same edge that accepts its last element.
  always_comb begin
    base   = clear ? '0 : acc;
    metric = base;
    if (en && !diag) begin
      if (mode == MODE_MAXABS) begin
        metric = (mag_ext > base) ? mag_ext : base;
      end else begin
        metric = base + sq_ext;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else begin
      acc <= metric;
    end
  end

endmodule

// File: rtl/converge_check_axi.sv
// rtl/converge_check_axi.sv - streaming matrix convergence detector with framing checks and stability count
module converge_check_axi
  import converge_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int N_STOCKS = 4,
  parameter int CONSEC   = 2,
  localparam int MW      = metric_width(WIDTH, N_STOCKS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             axiiv,
  input  logic [WIDTH-1:0] axiid,
  input  logic             axiil,
  output logic             axiir,
  input  logic             mode,
  input  logic [MW-1:0]    threshold,
  output logic             axiov,
  output logic             axiod,
  output logic [MW-1:0]    axiod_metric,
  output logic             axiod_stable,
  output logic             frame_err
);

  localparam int CW = $clog2(N_STOCKS);
  localparam int SW = $clog2(CONSEC + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_STOCKS - 1);
  localparam logic [SW-1:0] CONSEC_C = SW'(CONSEC);

  state_t          state, state_nxt;
  logic [CW-1:0]   row, col;
  logic            mode_q;
  logic [MW-1:0]   thr_q;
  logic [SW-1:0]   consec, consec_nxt;

  logic            in_idle, accept, last_pos, frame_end, clean, converged;
  logic            mode_eff;
  logic [MW-1:0]   thr_eff;
  logic [MW-1:0]   metric_nxt;

  assign in_idle   = (state == IDLE);
  assign axiir     = (state != DONE);
  assign accept    = axiiv && axiir;
  assign last_pos  = (row == LAST_IDX) && (col == LAST_IDX);
  assign frame_end = accept && (axiil || last_pos);
  assign clean     = axiil && last_pos;

  // The first element of a frame uses the live mode/threshold; later ones use the latched copy.
  assign mode_eff  = in_idle ? mode : mode_q;
  assign thr_eff   = in_idle ? threshold : thr_q;
  assign converged = (metric_nxt <= thr_eff);

  converge_metric_acc #(
    .WIDTH (WIDTH),
    .MW    (MW)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .en      (accept),
    .clear   (in_idle),
    .mode    (mode_eff),
    .diag    (row == col),
    .element (axiid),
    .metric  (metric_nxt)
  );

  always_comb begin
    state_nxt  = state;
    consec_nxt = '0;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          state_nxt = frame_end ? DONE : ACCUM;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clean && converged) begin
      consec_nxt = (consec == CONSEC_C) ? consec : consec + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      mode_q       <= MODE_SSQ;
      thr_q        <= '0;
      consec       <= '0;
      axiov        <= 1'b0;
      axiod        <= 1'b0;
      axiod_metric <= '0;
      axiod_stable <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      axiov <= frame_end;
      if (accept && in_idle) begin
        mode_q <= mode;
        thr_q  <= threshold;
      end
      if (frame_end) begin
        row <= '0;
        col <= '0;
      end else if (accept) begin
        if (col == LAST_IDX) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (frame_end) begin
        axiod_metric <= metric_nxt;
        axiod        <= converged;
        frame_err    <= !clean;
        consec       <= consec_nxt;
        axiod_stable <= (consec_nxt == CONSEC_C);
      end
    end
  end

endmodule
